// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard scan-code receiver with prefix decoding
//
// Receives 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop)
// on the system clock, folds 0xE0 / 0xF0 prefixes into flags and presents
// one key event per non-prefix byte.
//
// Optional feature: define PS2_RX_TIMEOUT_EN to abandon a frame when no
// ps2_clk falling edge arrives for TIMEOUT clk_sys cycles.
//
// Ports:
//   clk_sys      in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   ps2_clk      in   raw PS/2 clock (idles high)
//   ps2_data     in   raw PS/2 data
//   key_valid    out  one-cycle strobe, key event available
//   key_code     out  scan code of the last event (held)
//   key_extended out  last event was prefixed by 0xE0 (held)
//   key_released out  last event was prefixed by 0xF0 (held)
//   frame_err    out  one-cycle strobe, frame rejected
//   err_count    out  saturating count of rejected frames

module ps2_kbd_rx #(
  parameter int TIMEOUT = 2000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       frame_err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // A timeout below 2 cycles cannot be told apart from a normal bit period.
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("ps2_kbd_rx: TIMEOUT must be at least 2");
  end

  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_prev_q;
  logic       fall;
  logic       rx_bit;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       par_ok_q;
  logic       ext_flag_q;
  logic       rel_flag_q;

  logic       key_valid_q;
  logic [7:0] key_code_q;
  logic       key_extended_q;
  logic       key_released_q;
  logic       frame_err_q;
  logic [7:0] err_count_q;

  // Synchronizers reset to 1 so the idle-high lines never look like an edge
  // coming out of reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  // Edge is seen combinationally in the cycle the synchronized clock drops,
  // so the decode register lands on the third clk_sys edge after the raw fall.
  assign fall   = clk_prev_q & ~clk_sync_q[1];
  assign rx_bit = dat_sync_q[1];

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT);
  logic [TMO_W-1:0] tmo_cnt_q;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      bit_cnt_q      <= 3'd0;
      shift_q        <= 8'h00;
      par_ok_q       <= 1'b0;
      ext_flag_q     <= 1'b0;
      rel_flag_q     <= 1'b0;
      key_valid_q    <= 1'b0;
      key_code_q     <= 8'h00;
      key_extended_q <= 1'b0;
      key_released_q <= 1'b0;
      frame_err_q    <= 1'b0;
      err_count_q    <= 8'h00;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_cnt_q      <= '0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;

      if (fall) begin
`ifdef PS2_RX_TIMEOUT_EN
        tmo_cnt_q <= '0;
`endif
        case (state_q)
          S_IDLE: begin
            // A falling edge with data high is not a start bit; ignore it.
            if (!rx_bit) begin
              state_q   <= S_DATA;
              bit_cnt_q <= 3'd0;
            end
          end

          S_DATA: begin
            shift_q   <= {rx_bit, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_PARITY;
            end
          end

          S_PARITY: begin
            // Odd parity: XOR over data plus parity bit must be 1.
            par_ok_q <= ^{shift_q, rx_bit};
            state_q  <= S_STOP;
          end

          S_STOP: begin
            state_q <= S_IDLE;
            if (rx_bit && par_ok_q) begin
              if (shift_q == 8'hE0) begin
                ext_flag_q <= 1'b1;
              end else if (shift_q == 8'hF0) begin
                rel_flag_q <= 1'b1;
              end else begin
                key_valid_q    <= 1'b1;
                key_code_q     <= shift_q;
                key_extended_q <= ext_flag_q;
                key_released_q <= rel_flag_q;
                ext_flag_q     <= 1'b0;
                rel_flag_q     <= 1'b0;
              end
            end else begin
              frame_err_q <= 1'b1;
              ext_flag_q  <= 1'b0;
              rel_flag_q  <= 1'b0;
              if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
              end
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
`ifdef PS2_RX_TIMEOUT_EN
      else if (state_q != S_IDLE) begin
        if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          tmo_cnt_q   <= '0;
          state_q     <= S_IDLE;
          frame_err_q <= 1'b1;
          ext_flag_q  <= 1'b0;
          rel_flag_q  <= 1'b0;
          if (err_count_q != 8'hFF) begin
            err_count_q <= err_count_q + 8'd1;
          end
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
      end else begin
        tmo_cnt_q <= '0;
      end
`endif
    end
  end

  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign key_extended = key_extended_q;
  assign key_released = key_released_q;
  assign frame_err    = frame_err_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - scoreboard bench for ps2_kbd_rx
module tb_ps2_kbd_rx;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic       frame_err;
  logic [7:0] err_count;

  ps2_kbd_rx dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_extended (key_extended),
    .key_released (key_released),
    .frame_err    (frame_err),
    .err_count    (err_count)
  );

  always #5 clk_sys = ~clk_sys;

  localparam int K_NONE = 0;
  localparam int K_KEY  = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       ext;
    logic       rel;
    int         cyc;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per strobe.
  always @(negedge clk_sys) begin
    if (key_valid && frame_err) begin
      chk("strobes_exclusive", 32'd1, 32'd0);
    end
    if (key_valid || frame_err) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {30'd0, frame_err, key_valid}, 32'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("event_kind", key_valid ? K_KEY : K_ERR, e.kind);
        if (e.kind == K_KEY) begin
          chk("key_code", {24'd0, key_code}, {24'd0, e.code});
          chk("key_extended", {31'd0, key_extended}, {31'd0, e.ext});
          chk("key_released", {31'd0, key_released}, {31'd0, e.rel});
        end
        if (e.cyc >= 0) begin
          chk("event_latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic ps2_fall(input logic v);
    ps2_data = v;
    repeat (3) @(posedge clk_sys);
    #1 ps2_clk = 1'b0;
  endtask

  task automatic ps2_rise();
    repeat (6) @(posedge clk_sys);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int kind, input logic ext, input logic rel);
    logic [10:0] bits;
    ev_t e;
    bits = {stp, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_fall(bits[i]);
      if (i == 10 && kind != K_NONE) begin
        e.kind = kind;
        e.code = b;
        e.ext  = ext;
        e.rel  = rel;
        e.cyc  = cyc + 3;
        sb.push_back(e);
      end
      ps2_rise();
    end
    ps2_data = 1'b1;
    repeat (4) @(posedge clk_sys);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_key_valid"}, {31'd0, key_valid}, 32'd0);
    chk({tag, "_key_code"}, {24'd0, key_code}, 32'd0);
    chk({tag, "_key_extended"}, {31'd0, key_extended}, 32'd0);
    chk({tag, "_key_released"}, {31'd0, key_released}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
  endtask

  initial begin
    repeat (5) @(posedge clk_sys);
    #1 check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (5) @(posedge clk_sys);

    // Plain make code 0x1C
    send_frame(8'h1C, 1'b0, 1'b1, K_KEY, 1'b0, 1'b0);
    #1 chk("key_code_held", {24'd0, key_code}, 32'h1C);

    // E0 F0 75 -> extended release
    send_frame(8'hE0, 1'b0, 1'b1, K_NONE, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b1, K_NONE, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, K_KEY, 1'b1, 1'b1);

    // Parity error then good frame
    send_frame(8'h1C, 1'b1, 1'b1, K_ERR, 1'b0, 1'b0);
    #1 chk("err_count_after_parity", {24'd0, err_count}, 32'd1);
    send_frame(8'h1C, 1'b0, 1'b1, K_KEY, 1'b0, 1'b0);

    // Stop error after F0 prefix clears the released flag
    send_frame(8'hF0, 1'b1, 1'b1, K_NONE, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, K_ERR, 1'b0, 1'b0);
    #1 chk("err_count_after_stop", {24'd0, err_count}, 32'd2);
    send_frame(8'h1C, 1'b0, 1'b1, K_KEY, 1'b0, 1'b0);

    // Repeated prefixes are idempotent
    send_frame(8'hE0, 1'b0, 1'b1, K_NONE, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, K_NONE, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, K_KEY, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b1, K_NONE, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b1, K_NONE, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, K_NONE, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1, K_KEY, 1'b1, 1'b1);

    // Falling edge with data high in idle is ignored
    ps2_fall(1'b1);
    ps2_rise();
    send_frame(8'h1C, 1'b0, 1'b1, K_KEY, 1'b0, 1'b0);

`ifdef PS2_RX_TIMEOUT_EN
    begin
      ev_t e;
      ps2_fall(1'b0); ps2_rise();
      ps2_fall(1'b0); ps2_rise();
      ps2_fall(1'b0); ps2_rise();
      ps2_fall(1'b1); ps2_rise();
      e.kind = K_ERR; e.code = 8'h00; e.ext = 1'b0; e.rel = 1'b0; e.cyc = -1;
      sb.push_back(e);
      repeat (2100) @(posedge clk_sys);
      #1 chk("timeout_err_count", {24'd0, err_count}, 32'd3);
      send_frame(8'h1C, 1'b0, 1'b1, K_KEY, 1'b0, 1'b0);
    end
`endif

    // 300 bad frames saturate the counter
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) send_frame(8'h33, 1'b0, 1'b1, K_ERR, 1'b0, 1'b0);
      else            send_frame(8'h33, 1'b1, 1'b0, K_ERR, 1'b0, 1'b0);
    end
    #1 chk("err_count_saturated", {24'd0, err_count}, 32'd255);

    // Reset mid-frame after an F0 prefix
    send_frame(8'hF0, 1'b1, 1'b1, K_NONE, 1'b0, 1'b0);
    ps2_fall(1'b0); ps2_rise();
    ps2_fall(1'b1); ps2_rise();
    ps2_fall(1'b0); ps2_rise();
    @(posedge clk_sys);
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    repeat (5) @(posedge clk_sys);
    #1 check_reset_outputs("midframe_reset_hold");
    reset_n = 1'b1;
    repeat (5) @(posedge clk_sys);
    send_frame(8'h1C, 1'b0, 1'b1, K_KEY, 1'b0, 1'b0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk_sys);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
